// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter with split-transaction parking, fixed M1 priority and idle-grant timeout.
// Grants are registered (1-cycle latency); every grant is followed by at least one IDLE cycle.
module bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic M1_BREQ,
  input  logic M2_BREQ,
  input  logic B_UTIL,
  input  logic B_SPLIT,
  input  logic B_SBSY,
  output logic M1_BGRANT,
  output logic M2_BGRANT,
  output logic M_SEL,
  output logic SPLIT_PEND,
  output logic SPLIT_OWNER
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             pend_q, pend_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic owner_req;
  logic m1_parked;
  logic m2_parked;
  logic cur_req;
  logic cur_id;

  assign owner_req = owner_q ? M2_BREQ : M1_BREQ;
  assign m1_parked = pend_q && !owner_q;
  assign m2_parked = pend_q && owner_q;
  assign cur_id    = (state_q == GNT2);
  assign cur_req   = cur_id ? M2_BREQ : M1_BREQ;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;

    // A parked master that gives up its request no longer needs its slot.
    if (pend_q && !owner_req) begin
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_q && !B_SBSY && owner_req) begin
          pend_d  = 1'b0;
          state_d = owner_q ? GNT2 : GNT1;
          sel_d   = owner_q;
        end else if (M1_BREQ && !m1_parked) begin
          state_d = GNT1;
          sel_d   = 1'b0;
        end else if (M2_BREQ && !m2_parked) begin
          state_d = GNT2;
          sel_d   = 1'b1;
        end
      end

      GNT1, GNT2: begin
        if (!cur_req) begin
          state_d = IDLE;
        end else if (B_SPLIT && !pend_q) begin
          pend_d  = 1'b1;
          owner_d = cur_id;
          state_d = IDLE;
        end else if (B_UTIL) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // The counter reaches TIMEOUT on this edge, so the grant drops now.
          if (cnt_q >= TO_LAST) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign M1_BGRANT   = (state_q == GNT1);
  assign M2_BGRANT   = (state_q == GNT2);
  assign M_SEL       = sel_q;
  assign SPLIT_PEND  = pend_q;
  assign SPLIT_OWNER = owner_q;

endmodule
